hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
Parametrised data-hazard unit for the in-order RISC-V pipeline. It selects the operand forwarding source for the EX stage across NUM_STAGES later pipeline stages, with the youngest stage taking priority. It also generates load-use stalls for multi-cycle memory latency, and tracks long-latency ops (mul/div) in a register scoreboard. It sits beside the ID/EX register and drives the EX operand muxes and the IF/ID hold and ID/EX bubble controls.

Parameters:
M, 5, register address width (2**M architectural regs)
NUM_STAGES, 2, number of forwarding source stages; index 0 is youngest (EX/MEM), index 1 is MEM/WB
LOAD_USE_CYCLES, 1, stall cycles inserted per load-use hazard (≥1)
STAT_W, 32, statistics counter width (optional feature only)
SEL_W, $clog2(NUM_STAGES+1), localparam, forward select width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_rs1, ex_rs2  in  M  source regs of instruction in ID/EX
stage_regwrite  in  NUM_STAGES  per-stage writes-register flag
stage_rd  in  NUM_STAGES*M  per-stage dest reg, stage k at bits [k*M +: M]
id_rs1, id_rs2  in  M  source regs of instruction in IF/ID (decode)
id_rs1_used, id_rs2_used  in  1  decode instruction actually reads rs1/rs2
id_rd  in  M  decode dest reg
id_is_long  in  1  decode instruction is a long-latency op
id_ex_memread  in  1  ID/EX holds a load
id_ex_rd  in  M  ID/EX dest reg
lat_issue  in  1  long-latency op leaves ID this cycle (not stalled)
lat_rd  in  M  its dest reg
lat_done  in  1  long-latency result written back this cycle
lat_done_rd  in  M  dest reg of that result
flush  in  1  kill IF/ID and ID/EX (branch redirect)
rs1_sel, rs2_sel  out  SEL_W  0 = regfile value; k = forward from stage k-1
stall  out  1  hold PC and IF/ID
bubble  out  1  zero ID/EX control next edge

Behaviour:
- Forwarding is combinational. rsX_sel = k+1 for the lowest k where stage_regwrite[k] is set, stage_rd[k]==ex_rsX and ex_rsX!=0. Otherwise rsX_sel = 0.
- Load-use hazard (lu_hit): id_ex_memread && id_ex_rd!=0 && (id_rs1_used && id_rs1==id_ex_rd || id_rs2_used && id_rs2==id_ex_rd).
- Load-use FSM states:
  - IDLE: stall = lu_hit. If lu_hit && LOAD_USE_CYCLES>1, go to LU_WAIT with cnt = LOAD_USE_CYCLES-1.
  - LU_WAIT: stall = 1. cnt decrements each cycle; cnt==1 returns to IDLE. Total stall is exactly LOAD_USE_CYCLES cycles.
- Scoreboard: busy[2**M-1:0], registered.
  - lat_issue sets busy[lat_rd] at the edge. lat_done clears busy[lat_done_rd].
  - Same reg set and cleared in the same cycle: set wins.
  - busy[0] is never set.
- sb_hit = (id_rs1_used && busy[id_rs1]) || (id_rs2_used && busy[id_rs2]) || (id_is_long && busy[id_rd]) (RAW and WAW).
  - A reg with lat_done && lat_done_rd==reg in the current cycle counts as not busy. The regfile is write-before-read.
- stall = bubble = lu_stall || sb_hit. Suppressed to 0 when flush=1.
- flush: FSM goes to IDLE and cnt goes to 0 at the edge. Scoreboard is unaffected, because issued long ops still complete.
- rst: at the edge, FSM=IDLE, cnt=0, busy=0. While rst=1, stall=bubble=0 and rs1_sel=rs2_sel=0.
- lat_issue while stall=1 is a protocol error. Assert it in simulation.

Optional Feature:
HAZARD_STATS_EN
- Defined: adds outputs stat_stall_cycles, stat_lu_events, stat_fwd_events, each STAT_W wide.
  - stat_stall_cycles increments on each cycle with stall=1.
  - stat_lu_events increments on each IDLE→stall entry caused by lu_hit.
  - stat_fwd_events increments on each cycle with rs1_sel!=0 or rs2_sel!=0.
  - Counters saturate at all-ones and clear on rst.
- Undefined: the outputs and counters are absent; behaviour is otherwise identical.

Decomposition:
- hazard_pkg holds:
  - lu_state_e enum (IDLE, LU_WAIT)
  - FWD_NONE=0 constant
  - a function fwd_sel_of_stage(k) returning k+1
- Sub-module hazard_scoreboard (params M; ports clk, rst, set/set_rd, clr/clr_rd, query ports, outputs busy-hit) holds the busy vector and done-cycle bypass.

Test Plan:
- NUM_STAGES=2; stage0 and stage1 both write x5; ex_rs1=5 → rs1_sel=1. Clear stage0 regwrite → rs1_sel=2. ex_rs1=0 with stage0 rd=0 → rs1_sel=0.
- LOAD_USE_CYCLES=1: load to x7 in ID/EX, id_rs2=7 used → stall=bubble=1 for exactly 1 cycle. Same with id_rs2_used=0 → no stall.
- LOAD_USE_CYCLES=3: same hazard → stall high 3 consecutive cycles. flush asserted in the 2nd cycle → stall=0 that cycle, FSM IDLE next.
- lat_issue rd=x10; next cycle id_rs1=10 → stall=1 until lat_done rd=10. In the lat_done cycle stall=0. Same-cycle lat_issue x10 + lat_done x10 → busy[10] stays 1.
- id_is_long with id_rd=10 while busy[10] → stall (WAW). rst mid-stall → busy cleared, stall=0 next cycle.
- HAZARD_STATS_EN: run the 3-cycle load-use case twice → stat_stall_cycles=6, stat_lu_events=2. Force counters near max → saturate at all-ones.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding unit.
package hazard_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    LU_WAIT = 1'b1
  } lu_state_e;

  localparam int FWD_NONE = 0;

  // Forward select encoding: stage k is reached through mux input k+1.
  function automatic int fwd_sel_of_stage(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for long-latency ops, with a bypass that treats
// a register written back this cycle as already free.
module hazard_scoreboard #(
  parameter int M = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         set,
  input  logic [M-1:0] set_rd,
  input  logic         clr,
  input  logic [M-1:0] clr_rd,
  input  logic [M-1:0] rs1,
  input  logic         rs1_used,
  input  logic [M-1:0] rs2,
  input  logic         rs2_used,
  input  logic [M-1:0] rd,
  input  logic         rd_used,
  output logic         busy_hit
);

  localparam int NREG = 2 ** M;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_eff;

  always_comb begin
    clr_mask = '0;
    if (clr) clr_mask[clr_rd] = 1'b1;
    // Set is applied after clear so a same-cycle issue keeps the reg busy.
    busy_nxt = busy & ~clr_mask;
    if (set) busy_nxt[set_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    busy_eff = busy & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign busy_hit = (rs1_used && busy_eff[rs1]) ||
                    (rs2_used && busy_eff[rs2]) ||
                    (rd_used  && busy_eff[rd]);

endmodule

// File: rtl/hazard_forward_unit.sv
// EX operand forwarding, load-use stall FSM and long-latency scoreboard.
// Optional statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int M               = 5,
  parameter int NUM_STAGES      = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int STAT_W          = 32,
  localparam int SEL_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [M-1:0]          ex_rs1,
  input  logic [M-1:0]          ex_rs2,
  input  logic [NUM_STAGES-1:0] stage_regwrite,
  input  logic [NUM_STAGES*M-1:0] stage_rd,
  input  logic [M-1:0]          id_rs1,
  input  logic [M-1:0]          id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [M-1:0]          id_rd,
  input  logic                  id_is_long,
  input  logic                  id_ex_memread,
  input  logic [M-1:0]          id_ex_rd,
  input  logic                  lat_issue,
  input  logic [M-1:0]          lat_rd,
  input  logic                  lat_done,
  input  logic [M-1:0]          lat_done_rd,
  input  logic                  flush,
  output logic [SEL_W-1:0]      rs1_sel,
  output logic [SEL_W-1:0]      rs2_sel,
  output logic                  stall,
  output logic                  bubble
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0]     stat_stall_cycles,
  output logic [STAT_W-1:0]     stat_lu_events,
  output logic [STAT_W-1:0]     stat_fwd_events
`endif
);

  localparam int CNT_W = $clog2(LOAD_USE_CYCLES + 1);

  lu_state_e  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic lu_hit, lu_stall, sb_hit;

  // Walk from oldest to youngest so the youngest matching stage wins.
  always_comb begin
    rs1_sel = SEL_W'(FWD_NONE);
    rs2_sel = SEL_W'(FWD_NONE);
    if (!rst) begin
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (stage_regwrite[k] && stage_rd[k*M +: M] == ex_rs1 && ex_rs1 != '0)
          rs1_sel = SEL_W'(fwd_sel_of_stage(k));
        if (stage_regwrite[k] && stage_rd[k*M +: M] == ex_rs2 && ex_rs2 != '0)
          rs2_sel = SEL_W'(fwd_sel_of_stage(k));
      end
    end
  end

  assign lu_hit = id_ex_memread && (id_ex_rd != '0) &&
                  ((id_rs1_used && id_rs1 == id_ex_rd) ||
                   (id_rs2_used && id_rs2 == id_ex_rd));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lu_stall  = 1'b0;
    case (state)
      IDLE: begin
        lu_stall = lu_hit;
        if (lu_hit && LOAD_USE_CYCLES > 1) begin
          state_nxt = LU_WAIT;
          cnt_nxt   = CNT_W'(LOAD_USE_CYCLES - 1);
        end
      end
      LU_WAIT: begin
        lu_stall = 1'b1;
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  hazard_scoreboard #(.M(M)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set      (lat_issue),
    .set_rd   (lat_rd),
    .clr      (lat_done),
    .clr_rd   (lat_done_rd),
    .rs1      (id_rs1),
    .rs1_used (id_rs1_used),
    .rs2      (id_rs2),
    .rs2_used (id_rs2_used),
    .rd       (id_rd),
    .rd_used  (id_is_long),
    .busy_hit (sb_hit)
  );

  assign stall  = !rst && !flush && (lu_stall || sb_hit);
  assign bubble = stall;

  always_ff @(posedge clk) begin
    if (!rst && lat_issue)
      assert (!stall) else $error("lat_issue asserted while stall is high");
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_stall_cycles <= '0;
      stat_lu_events    <= '0;
      stat_fwd_events   <= '0;
    end else begin
      if (stall) stat_stall_cycles <= sat_inc(stat_stall_cycles);
      if (stall && state == IDLE && lu_hit) stat_lu_events <= sat_inc(stat_lu_events);
      if (rs1_sel != '0 || rs2_sel != '0) stat_fwd_events <= sat_inc(stat_fwd_events);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: one-cycle and three-cycle load-use instances share stimulus.
module tb_hazard_forward_unit;
  localparam int M  = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [M-1:0]  ex_rs1, ex_rs2, id_rs1, id_rs2, id_rd, id_ex_rd, lat_rd, lat_done_rd;
  logic [NS-1:0] stage_regwrite;
  logic [NS*M-1:0] stage_rd;
  logic id_rs1_used, id_rs2_used, id_is_long, id_ex_memread, lat_issue, lat_done, flush;

  logic [1:0] a_rs1_sel, a_rs2_sel, b_rs1_sel, b_rs2_sel;
  logic a_stall, a_bubble, b_stall, b_bubble;
`ifdef HAZARD_STATS_EN
  logic [31:0] a_sc, a_le, a_fe, b_sc, b_le, b_fe;
  logic [1:0]  c_rs1_sel, c_rs2_sel, c_sc, c_le, c_fe;
  logic        c_stall, c_bubble;
`endif

  int errors = 0;
  int checks = 0;

  hazard_forward_unit #(.M(M), .NUM_STAGES(NS), .LOAD_USE_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .stage_regwrite(stage_regwrite), .stage_rd(stage_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_is_long(id_is_long), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .lat_issue(lat_issue), .lat_rd(lat_rd), .lat_done(lat_done), .lat_done_rd(lat_done_rd),
    .flush(flush), .rs1_sel(a_rs1_sel), .rs2_sel(a_rs2_sel), .stall(a_stall), .bubble(a_bubble)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(a_sc), .stat_lu_events(a_le), .stat_fwd_events(a_fe)
`endif
  );

  hazard_forward_unit #(.M(M), .NUM_STAGES(NS), .LOAD_USE_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .stage_regwrite(stage_regwrite), .stage_rd(stage_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_is_long(id_is_long), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .lat_issue(lat_issue), .lat_rd(lat_rd), .lat_done(lat_done), .lat_done_rd(lat_done_rd),
    .flush(flush), .rs1_sel(b_rs1_sel), .rs2_sel(b_rs2_sel), .stall(b_stall), .bubble(b_bubble)
`ifdef HAZARD_STATS_EN
    , .stat_stall_cycles(b_sc), .stat_lu_events(b_le), .stat_fwd_events(b_fe)
`endif
  );

`ifdef HAZARD_STATS_EN
  hazard_forward_unit #(.M(M), .NUM_STAGES(NS), .LOAD_USE_CYCLES(3), .STAT_W(2)) u_c (
    .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .stage_regwrite(stage_regwrite), .stage_rd(stage_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_is_long(id_is_long), .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .lat_issue(lat_issue), .lat_rd(lat_rd), .lat_done(lat_done), .lat_done_rd(lat_done_rd),
    .flush(flush), .rs1_sel(c_rs1_sel), .rs2_sel(c_rs2_sel), .stall(c_stall), .bubble(c_bubble),
    .stat_stall_cycles(c_sc), .stat_lu_events(c_le), .stat_fwd_events(c_fe)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ex_rs1 = '0; ex_rs2 = '0; stage_regwrite = '0; stage_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = '0; id_is_long = 0; id_ex_memread = 0; id_ex_rd = '0;
    lat_issue = 0; lat_rd = '0; lat_done = 0; lat_done_rd = '0; flush = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // Hazards present during reset must not reach the outputs
    stage_regwrite = 2'b01; stage_rd = {5'd0, 5'd5}; ex_rs1 = 5;
    id_ex_memread = 1; id_ex_rd = 7; id_rs1 = 7; id_rs1_used = 1;
    tick(); tick();
    chk("rst_rs1_sel", 32'(a_rs1_sel), 0);
    chk("rst_stall", 32'(a_stall), 0);
    chk("rst_bubble_b", 32'(b_bubble), 0);
    idle_inputs(); rst = 1'b0;
    tick();

    // Forwarding priority, one edge per vector
    stage_regwrite = 2'b11; stage_rd = {5'd5, 5'd5}; ex_rs1 = 5; #1;
    chk("fwd_youngest", 32'(a_rs1_sel), 1);
    chk("fwd_rs2_none", 32'(a_rs2_sel), 0);
    tick();
    stage_regwrite = 2'b10; #1;
    chk("fwd_older", 32'(a_rs1_sel), 2);
    tick();
    stage_regwrite = 2'b11; stage_rd = {5'd5, 5'd0}; ex_rs1 = 0; #1;
    chk("fwd_x0", 32'(a_rs1_sel), 0);
    tick();
    stage_regwrite = 2'b10; stage_rd = {5'd9, 5'd0}; ex_rs2 = 9; #1;
    chk("fwd_rs2_older", 32'(b_rs2_sel), 2);
    tick();
    idle_inputs();

    // Load-use run 1
    id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_rs2_used = 1; #1;
    chk("lu1_stall", 32'(a_stall), 1);
    chk("lu1_bubble", 32'(a_bubble), 1);
    chk("lu3_c1", 32'(b_stall), 1);
    tick();
    id_ex_memread = 0; #1;
    chk("lu1_one_cycle", 32'(a_stall), 0);
    chk("lu3_c2", 32'(b_stall), 1);
    tick(); #1;
    chk("lu3_c3", 32'(b_stall), 1);
    tick(); #1;
    chk("lu3_end", 32'(b_stall), 0);

    id_ex_memread = 1; id_rs2_used = 0; #1;
    chk("lu_unused_a", 32'(a_stall), 0);
    chk("lu_unused_b", 32'(b_stall), 0);
    tick();
    id_ex_rd = 0; id_rs1 = 0; id_rs1_used = 1; #1;
    chk("lu_rd_x0", 32'(a_stall), 0);
    tick();
    idle_inputs();

    // Load-use run 2
    id_ex_memread = 1; id_ex_rd = 7; id_rs2 = 7; id_rs2_used = 1;
    tick();
    id_ex_memread = 0;
    tick(); tick();
    chk("lu3_run2_end", 32'(b_stall), 0);
`ifdef HAZARD_STATS_EN
    chk("stat_b_stall", b_sc, 6);
    chk("stat_b_lu", b_le, 2);
    chk("stat_b_fwd", b_fe, 3);
    chk("stat_a_stall", a_sc, 2);
    chk("stat_c_stall_sat", 32'(c_sc), 3);
    chk("stat_c_lu", 32'(c_le), 2);
`endif

    // Flush during the load-use wait
    id_ex_memread = 1; #1;
    chk("flush_c1", 32'(b_stall), 1);
    tick();
    id_ex_memread = 0; flush = 1; #1;
    chk("flush_stall", 32'(b_stall), 0);
    chk("flush_bubble", 32'(b_bubble), 0);
    tick();
    flush = 0; #1;
    chk("flush_idle", 32'(b_stall), 0);
    idle_inputs();

    // Scoreboard RAW and done-cycle bypass
    lat_issue = 1; lat_rd = 10; #1;
    tick();
    lat_issue = 0; id_rs1 = 10; id_rs1_used = 1; #1;
    chk("sb_raw", 32'(a_stall), 1);
    tick(); #1;
    chk("sb_raw_hold", 32'(b_stall), 1);
    lat_done = 1; lat_done_rd = 10; #1;
    chk("sb_done_bypass", 32'(a_stall), 0);
    tick();
    lat_done = 0; #1;
    chk("sb_cleared", 32'(a_stall), 0);

    // Same-cycle set and clear keeps the register busy
    id_rs1_used = 0; lat_issue = 1; lat_rd = 10;
    tick();
    lat_done = 1; lat_done_rd = 10;
    tick();
    lat_issue = 0; lat_done = 0; id_rs1_used = 1; #1;
    chk("sb_set_wins", 32'(a_stall), 1);

    // WAW on a busy destination, then reset clears the scoreboard
    id_rs1_used = 0; id_is_long = 1; id_rd = 10; #1;
    chk("sb_waw", 32'(b_stall), 1);
    rst = 1; #1;
    chk("rst_gate", 32'(a_stall), 0);
    tick();
    rst = 0; #1;
    chk("rst_busy_clr", 32'(a_stall), 0);

    // x0 is never marked busy
    lat_issue = 1; lat_rd = 0;
    tick();
    lat_issue = 0; id_is_long = 0; id_rs1 = 0; id_rs1_used = 1; #1;
    chk("sb_x0", 32'(a_stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
